// File: rtl/vec_pkg.sv
// Shared constants and types for the vec_loader / vec_mul operand path.
package vec_pkg;

    localparam int C       = 9;
    localparam int W_X     = 8;
    localparam int W_K     = 8;
    localparam int W_CNT   = $clog2(C);
    localparam int W_Y     = W_X + W_K + $clog2(C);
    localparam int LATENCY = $clog2(C) + 1;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } loader_state_e;

endpackage

// File: rtl/vec_loader.sv
// Serial-to-parallel (x, k) loader: packs up to C element pairs per vector,
// zero-pads short vectors, and presents them on a registered valid/ready output.
module vec_loader #(
    parameter int  C     = vec_pkg::C,
    parameter int  W_X   = vec_pkg::W_X,
    parameter int  W_K   = vec_pkg::W_K,
    localparam int W_CNT = $clog2(C)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [W_X-1:0]                s_x,
    input  logic [W_K-1:0]                s_k,
    input  logic                          s_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [C-1:0][W_X-1:0]         x,
    output logic [C-1:0][W_K-1:0]         k,
    output vec_pkg::loader_state_e        dbg_state,
    output logic [W_CNT-1:0]              dbg_cnt
);

    // Handshake: a beat moves on a rising edge where valid && ready; the
    // sender holds data stable until then and the receiver never retracts ready
    // except through its own state change on an edge.

    vec_pkg::loader_state_e    r_state;
    vec_pkg::loader_state_e    w_next_state;
    logic                      r_live;
    logic [W_CNT-1:0]          r_cnt;
    logic [C-1:0][W_X-1:0]     r_buf_x;
    logic [C-1:0][W_K-1:0]     r_buf_k;
    logic [C-1:0][W_X-1:0]     r_x;
    logic [C-1:0][W_K-1:0]     r_k;
    logic                      r_m_valid;

    logic                      w_accept;
    logic                      w_complete;
    logic                      w_slot_free;
    logic                      w_load_img;
    logic                      w_load_buf;
    logic                      w_hold_img;
    logic [C-1:0][W_X-1:0]     w_img_x;
    logic [C-1:0][W_K-1:0]     w_img_k;

    // s_ready stays low until the first edge after reset releases.
    assign s_ready     = r_live && (r_state == vec_pkg::FILL);
    assign w_accept    = s_valid && s_ready;
    assign w_complete  = w_accept && ((r_cnt == W_CNT'(C - 1)) || s_last);
    assign w_slot_free = !r_m_valid || m_ready;

    // Transfer image: lanes below cnt from the buffer, lane cnt from the input,
    // lanes above cnt forced to zero so stale data never escapes.
    always_comb begin
        w_img_x = '0;
        w_img_k = '0;
        for (int i = 0; i < C; i++) begin
            if (i < int'(r_cnt)) begin
                w_img_x[i] = r_buf_x[i];
                w_img_k[i] = r_buf_k[i];
            end else if (i == int'(r_cnt)) begin
                w_img_x[i] = s_x;
                w_img_k[i] = s_k;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= vec_pkg::FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            vec_pkg::FILL: if (w_complete && !w_slot_free) w_next_state = vec_pkg::FULL;
            vec_pkg::FULL: if (m_ready) w_next_state = vec_pkg::FILL;
            default:       w_next_state = vec_pkg::FILL;
        endcase
    end

    always_comb begin
        w_load_img = 1'b0;
        w_hold_img = 1'b0;
        w_load_buf = 1'b0;
        case (r_state)
            vec_pkg::FILL: begin
                w_load_img = w_complete && w_slot_free;
                w_hold_img = w_complete && !w_slot_free;
            end
            vec_pkg::FULL: w_load_buf = m_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live    <= 1'b0;
            r_cnt     <= '0;
            r_buf_x   <= '0;
            r_buf_k   <= '0;
            r_x       <= '0;
            r_k       <= '0;
            r_m_valid <= 1'b0;
        end else begin
            r_live <= 1'b1;

            if (w_complete) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + W_CNT'(1);
            end

            // A blocked vector parks its already-masked image in the fill buffer.
            if (w_hold_img) begin
                r_buf_x <= w_img_x;
                r_buf_k <= w_img_k;
            end else if (w_accept) begin
                for (int i = 0; i < C; i++) begin
                    if (i == int'(r_cnt)) begin
                        r_buf_x[i] <= s_x;
                        r_buf_k[i] <= s_k;
                    end
                end
            end

            if (w_load_img) begin
                r_x <= w_img_x;
                r_k <= w_img_k;
            end else if (w_load_buf) begin
                r_x <= r_buf_x;
                r_k <= r_buf_k;
            end

            if (w_load_img || w_load_buf) begin
                r_m_valid <= 1'b1;
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_valid   = r_m_valid;
    assign x         = r_x;
    assign k         = r_k;
    assign dbg_state = r_state;
    assign dbg_cnt   = r_cnt;

endmodule

// File: tb/tb_vec_loader.sv
// Directed table plus corner-case sequences and a random soak for vec_loader.
module tb_vec_loader;

  localparam int C     = vec_pkg::C;
  localparam int W_X   = vec_pkg::W_X;
  localparam int W_K   = vec_pkg::W_K;
  localparam int W_CNT = $clog2(C);
  localparam int VW    = C * (W_X + W_K);

  typedef logic [C-1:0][W_X-1:0] xvec_t;
  typedef logic [C-1:0][W_K-1:0] kvec_t;

  typedef struct {
    int     len;
    xvec_t  xs;
    kvec_t  ks;
    longint exp_y;
  } vec_t;

  logic                   clk;
  logic                   rst;
  logic                   s_valid;
  logic                   s_ready;
  logic [W_X-1:0]         s_x;
  logic [W_K-1:0]         s_k;
  logic                   s_last;
  logic                   m_valid;
  logic                   m_ready;
  xvec_t                  x;
  kvec_t                  k;
  vec_pkg::loader_state_e dbg_state;
  logic [W_CNT-1:0]       dbg_cnt;

  int checks = 0;
  int errors = 0;

  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] sb_e;
  xvec_t         acc_x;
  kvec_t         acc_k;
  int            acc_cnt;
  bit            rand_mr;

  vec_t  tbl[5];
  xvec_t ex;
  kvec_t ek;

  vec_loader dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_x       (s_x),
    .s_k       (s_k),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .x         (x),
    .k         (k),
    .dbg_state (dbg_state),
    .dbg_cnt   (dbg_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic longint dot(input xvec_t xv, input kvec_t kv);
    longint s = 0;
    for (int i = 0; i < C; i++) begin
      s += longint'($signed(xv[i])) * longint'($signed(kv[i]));
    end
    return s;
  endfunction

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: input-side model builds padded vectors, output side consumes them
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got vector %h expected none", {x, k});
        end else begin
          sb_e = exp_q.pop_front();
          check_vec("sb_vec", {x, k}, sb_e);
          check("sb_y", dot(x, k), dot(sb_e[VW-1 -: C*W_X], sb_e[C*W_K-1:0]));
        end
      end
      if (s_valid && s_ready) begin
        acc_x[acc_cnt] = s_x;
        acc_k[acc_cnt] = s_k;
        if (s_last || acc_cnt == C - 1) begin
          exp_q.push_back({acc_x, acc_k});
          acc_x   = '0;
          acc_k   = '0;
          acc_cnt = 0;
        end else begin
          acc_cnt++;
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_mr) m_ready = 1'($urandom_range(0, 1));
  end

  // driver tasks (called just after a rising edge)
  task automatic send_beat(input logic [W_X-1:0] bx, input logic [W_K-1:0] bk, input logic bl);
    bit acc = 0;
    s_valid = 1'b1;
    s_x     = bx;
    s_k     = bk;
    s_last  = bl;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (s_ready) begin
        acc = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got s_ready 0 expected 1 within 2000 cycles");
    end else begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic clear_model();
    exp_q.delete();
    acc_x   = '0;
    acc_k   = '0;
    acc_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_x     = '0;
    s_k     = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    rand_mr = 0;
    clear_model();

    tbl[0].len = 9; tbl[0].exp_y = 90;
    tbl[1].len = 3; tbl[1].exp_y = -30;
    tbl[2].len = 1; tbl[2].exp_y = 16384;
    tbl[3].len = 9; tbl[3].exp_y = -146304;
    tbl[4].len = 8; tbl[4].exp_y = -36;
    for (int i = 0; i < C; i++) begin
      tbl[0].xs[i] = W_X'(i + 1);     tbl[0].ks[i] = W_K'(2);
      tbl[1].xs[i] = W_X'(-(i + 1));  tbl[1].ks[i] = W_K'(5);
      tbl[2].xs[i] = 8'h80;           tbl[2].ks[i] = 8'h80;
      tbl[3].xs[i] = 8'h7f;           tbl[3].ks[i] = 8'h80;
      tbl[4].xs[i] = W_X'(i + 1);     tbl[4].ks[i] = 8'hff;
    end

    // reset values
    #2;
    check("rst_m_valid", m_valid, 0);
    check_vec("rst_xk", {x, k}, '0);
    check("rst_s_ready", s_ready, 0);
    check("rst_state", dbg_state, vec_pkg::FILL);
    check("rst_cnt", dbg_cnt, 0);
    idle(2);
    rst = 1'b0;
    idle(1);
    check("rst_release_s_ready", s_ready, 1);

    // table-driven vectors, m_ready held high
    m_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      ex = '0;
      ek = '0;
      for (int b = 0; b < tbl[t].len; b++) begin
        ex[b] = tbl[t].xs[b];
        ek[b] = tbl[t].ks[b];
        if (b == tbl[t].len - 1 && b > 0) check("tbl_mvalid_before", m_valid, 0);
        send_beat(tbl[t].xs[b], tbl[t].ks[b], (b == tbl[t].len - 1) && (tbl[t].len < C));
      end
      check("tbl_mvalid", m_valid, 1);
      check_vec("tbl_lanes", {x, k}, {ex, ek});
      check("tbl_y", dot(x, k), tbl[t].exp_y);
    end
    idle(2);

    // back-to-back length-1 vectors
    for (int i = 0; i < 3; i++) send_beat(W_X'(i + 7), W_K'(-(i + 1)), 1'b1);
    check("b2b_mvalid", m_valid, 1);
    check("b2b_lane0", x[0], 9);
    idle(2);

    // backpressure: 18 elements with m_ready low
    m_ready = 1'b0;
    for (int i = 0; i < 18; i++) send_beat(W_X'(i + 10), W_K'(i + 3), 1'b0);
    check("bp_state_full", dbg_state, vec_pkg::FULL);
    check("bp_s_ready", s_ready, 0);
    check("bp_mvalid", m_valid, 1);
    for (int i = 0; i < C; i++) begin
      ex[i] = W_X'(i + 10);
      ek[i] = W_K'(i + 3);
    end
    check_vec("bp_vec1", {x, k}, {ex, ek});
    m_ready = 1'b1;
    idle(1);
    m_ready = 1'b0;
    for (int i = 0; i < C; i++) begin
      ex[i] = W_X'(i + 19);
      ek[i] = W_K'(i + 12);
    end
    check("bp_swap_mvalid", m_valid, 1);
    check("bp_swap_s_ready", s_ready, 1);
    check("bp_swap_state", dbg_state, vec_pkg::FILL);
    check("bp_swap_cnt", dbg_cnt, 0);
    check_vec("bp_vec2", {x, k}, {ex, ek});
    m_ready = 1'b1;
    idle(2);
    check("bp_drained_q", exp_q.size(), 0);
    check("bp_drained_mvalid", m_valid, 0);

    // completing beat on the same edge as the consuming m_ready
    m_ready = 1'b0;
    send_beat(8'h11, 8'h01, 1'b0);
    send_beat(8'h22, 8'h01, 1'b1);
    send_beat(8'h33, 8'h02, 1'b0);
    send_beat(8'h44, 8'h03, 1'b0);
    m_ready = 1'b1;
    send_beat(8'h55, 8'h04, 1'b1);
    ex = '0;
    ek = '0;
    ex[0] = 8'h33; ex[1] = 8'h44; ex[2] = 8'h55;
    ek[0] = 8'h02; ek[1] = 8'h03; ek[2] = 8'h04;
    check("simul_mvalid", m_valid, 1);
    check_vec("simul_vec", {x, k}, {ex, ek});
    idle(2);

    // reset mid-vector with a held output
    m_ready = 1'b0;
    for (int i = 0; i < C; i++) send_beat(8'h70, 8'h01, 1'b0);
    for (int i = 0; i < 4; i++) send_beat(W_X'(i + 90), 8'h05, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_mvalid", m_valid, 0);
    check_vec("mid_rst_xk", {x, k}, '0);
    check("mid_rst_s_ready", s_ready, 0);
    check("mid_rst_cnt", dbg_cnt, 0);
    clear_model();
    idle(2);
    rst = 1'b0;
    idle(1);
    check("mid_rst_release_s_ready", s_ready, 1);
    m_ready = 1'b1;
    for (int i = 0; i < C; i++) begin
      ex[i] = W_X'(i + 64);
      ek[i] = W_K'(i + 1);
      send_beat(ex[i], ek[i], 1'b0);
    end
    check_vec("mid_rst_fresh_vec", {x, k}, {ex, ek});
    idle(2);

    // random soak
    rand_mr = 1;
    for (int v = 0; v < 1000; v++) begin
      int len;
      len = $urandom_range(1, C);
      for (int b = 0; b < len; b++) begin
        repeat ($urandom_range(0, 1)) begin
          s_x = W_X'($urandom);
          s_k = W_K'($urandom);
          idle(1);
        end
        send_beat(W_X'($urandom), W_K'($urandom),
                  (b == len - 1) && ((len < C) || ($urandom_range(0, 1) == 1)));
      end
    end
    rand_mr = 0;
    idle(1);
    m_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (exp_q.size() == 0 && !m_valid) break;
      idle(1);
    end
    check("soak_drain_q", exp_q.size(), 0);
    check("soak_drain_mvalid", m_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
